map_probe_server: RTL and testbench
===================================

# map_probe_server

Shared responder for all map-pixel lookups: accepts (x, y) probe requests from up to NREQ detectors (death, collision, ground and wall checks), arbitrates them round-robin onto the single synchronous map ROM port, and returns the 24-bit map color plus hazard classification. Detectors no longer instantiate their own ROM copies; each issues probes through this block and consumes a tagged response stream. It sits between the character/physics logic and `map1_rom`.

## Interface
- NREQ, 4, number of requesters (2..8)
- MAP_W, 640, screen width in pixels; probes with x >= MAP_W are out of bounds
- MAP_H, 480, screen height in pixels; probes with y >= MAP_H are out of bounds
- Clk  in  1  system clock; all state rises on posedge
- Reset  in  1  asynchronous, active-low
- req_valid  in  NREQ  per-requester probe valid
- req_x  in  NREQ*10  packed pixel x; requester i uses bits [10i+9:10i]
- req_y  in  NREQ*10  packed pixel y, same packing
- req_ready  out  NREQ  one-hot grant; the probe transfers when valid & ready
- rom_addr  out  17  registered map ROM address
- rom_data  in  24  map ROM output, valid one cycle after rom_addr is presented
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  3  requester index of the response
- rsp_color  out  24  map color at the probed pixel
- rsp_oob  out  1  probe was out of bounds
- rsp_lava  out  1  rsp_color == 24'hac0404
- rsp_poison  out  1  rsp_color == 24'h69a42a

## Operation
- Arbiter: rotating priority pointer `ptr`, reset 0. The grant goes to the first i with req_valid[i], scanning ptr, ptr+1, ... mod NREQ.
- req_ready is combinational, one-hot or zero. It is nonzero only for the granted valid requester.
- After a grant to i, ptr becomes (i+1) mod NREQ. With no grant, ptr holds.
- Requesters hold valid, x and y stable until ready. There is no response backpressure: requesters must sink rsp_valid whenever it is asserted.
- Address: rom_addr = x[9:2] + y[9:2]*160. The result is 17 bits wide, and the maximum in-bounds value is 19199.
- Out of bounds (x >= MAP_W or y >= MAP_H):
  - the request is still accepted and rom_addr is driven to 0;
  - the response carries rsp_oob=1 and rsp_color=0, and the ROM data is ignored;
  - hazard flags are 0.
- Stage 1 (accept edge): register rom_addr, id and the oob bit.
- Stage 2: the ROM samples rom_addr; id and oob are carried alongside.
- Stage 3: capture rom_data (or 0 if oob) into rsp_color. Hazard flags are registered in the same stage. rsp_valid=1 for one cycle.
- Throughput: one probe per cycle. Responses return in acceptance order.

## Timing
- Accept at edge E0 → rom_addr valid after E0 → rom_data valid after E1 → rsp_* valid after E2. Latency is 2 cycles, accept edge to response.
- Back-to-back accepts produce back-to-back rsp_valid.
- Reset asserted, at any time including mid-flight:
  - all outputs go to 0, ptr goes to 0, and in-flight probes are dropped with no rsp_valid;
  - req_ready stays 0 while Reset is low;
  - the first grant is possible on the first edge after deassertion.
- Simultaneous valids: exactly one grant per cycle. Any requester waits at most NREQ-1 cycles.
- A requester deasserting valid without a grant is legal; nothing is recorded.

## Configuration
- MAP_PROBE_HAZARD_CLASS_EN
  - Defined: rsp_lava and rsp_poison are computed and registered as above.
  - Undefined: both are tied to 0, the compare logic is removed, and all other behaviour is unchanged.

## Test plan
- Single probe, requester 0 at (100,40), ROM returns 24'hac0404:
  - rom_addr=1625 after the accept edge;
  - 2 cycles later rsp_valid=1, rsp_id=0, rsp_color=ac0404, rsp_lava=1, rsp_oob=0.
- All 4 valid at once after reset: grants in order 0,1,2,3 on consecutive cycles, and 4 consecutive responses with ids 0,1,2,3.
- Requesters 0 and 2 held valid continuously: grants alternate 0,2,0,2. Requesters 1 and 3 receive none.
- Out-of-bounds probe, requester 1 at (640,10): rom_addr=0, rsp_oob=1, rsp_color=0, and both hazard flags are 0.
- Reset pulled low one cycle after an accept: no rsp_valid appears. After release, ptr=0 and requester 0 wins a tie.
- Macro undefined, ROM returns 24'h69a42a: rsp_poison=0 and rsp_color=69a42a.

Source files
------------

// File: rtl/map_probe_server.sv
// Shared map-pixel probe server: round-robin arbitration onto one synchronous map ROM port,
// returning tagged color/out-of-bounds responses 2 cycles after accept. Hazard flags are
// generated only when MAP_PROBE_HAZARD_CLASS_EN is defined.
module map_probe_server #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned MAP_W = 640,
    parameter int unsigned MAP_H = 480
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*10-1:0]   req_x_i,
    input  logic [NREQ*10-1:0]   req_y_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [16:0]          rom_addr_o,
    input  logic [23:0]          rom_data_i,
    output logic                 rsp_valid_o,
    output logic [2:0]           rsp_id_o,
    output logic [23:0]          rsp_color_o,
    output logic                 rsp_oob_o,
    output logic                 rsp_lava_o,
    output logic                 rsp_poison_o
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic            gnt_found;
    logic [IdxW-1:0] gnt_idx;
    int unsigned     scan;
    int unsigned     nxt;

    // First valid requester at or after the rotating pointer wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan = (32'(ptr_q) + k) % NREQ;
            if (!gnt_found && req_valid_i[scan[IdxW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[IdxW-1:0];
            end
        end
    end

    always_comb begin
        nxt   = (32'(gnt_idx) + 1) % NREQ;
        ptr_d = gnt_found ? nxt[IdxW-1:0] : ptr_q;
    end

    always_comb begin
        req_ready_o = '0;
        if (rst_ni && gnt_found) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    logic [9:0]  sel_x, sel_y;
    logic        sel_oob;
    logic [16:0] sel_addr;

    always_comb begin
        sel_x    = req_x_i[gnt_idx*10 +: 10];
        sel_y    = req_y_i[gnt_idx*10 +: 10];
        sel_oob  = (32'(sel_x) >= MAP_W) || (32'(sel_y) >= MAP_H);
        sel_addr = 17'(sel_x[9:2]) + 17'(sel_y[9:2]) * 17'd160;
        if (sel_oob) begin
            sel_addr = '0;
        end
    end

    logic            s1_valid_q, s1_oob_q;
    logic [IdxW-1:0] s1_id_q;
    logic [16:0]     rom_addr_q;
    logic            s2_valid_q, s2_oob_q;
    logic [IdxW-1:0] s2_id_q;
    logic            rsp_valid_q, rsp_oob_q;
    logic [2:0]      rsp_id_q;
    logic [23:0]     rsp_color_q;
    logic [23:0]     color_d;

    // ROM data is meaningless for out-of-bounds probes.
    assign color_d = s2_oob_q ? 24'h0 : rom_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_oob_q    <= 1'b0;
            s1_id_q     <= '0;
            rom_addr_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_oob_q    <= 1'b0;
            s2_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_oob_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_color_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= gnt_found;
            if (gnt_found) begin
                rom_addr_q <= sel_addr;
                s1_id_q    <= gnt_idx;
                s1_oob_q   <= sel_oob;
            end
            s2_valid_q  <= s1_valid_q;
            s2_id_q     <= s1_id_q;
            s2_oob_q    <= s1_oob_q;
            rsp_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                rsp_id_q    <= 3'(s2_id_q);
                rsp_oob_q   <= s2_oob_q;
                rsp_color_q <= color_d;
            end
        end
    end

    assign rom_addr_o  = rom_addr_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_oob_o   = rsp_oob_q;
    assign rsp_color_o = rsp_color_q;

`ifdef MAP_PROBE_HAZARD_CLASS_EN
    localparam logic [23:0] LavaColor   = 24'hac0404;
    localparam logic [23:0] PoisonColor = 24'h69a42a;

    logic lava_q, poison_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lava_q   <= 1'b0;
            poison_q <= 1'b0;
        end else if (s2_valid_q) begin
            lava_q   <= (color_d == LavaColor);
            poison_q <= (color_d == PoisonColor);
        end
    end

    assign rsp_lava_o   = lava_q;
    assign rsp_poison_o = poison_q;
`else
    assign rsp_lava_o   = 1'b0;
    assign rsp_poison_o = 1'b0;
`endif

endmodule

// File: tb/tb_map_probe_server.sv
// Bench for map_probe_server: directed grant table, hand-written reset/ordering sequences and
// randomized probes checked against a transaction-level arbiter/ROM scoreboard.
module tb_map_probe_server;

    localparam int NREQ = 4;
`ifdef MAP_PROBE_HAZARD_CLASS_EN
    localparam bit HazEn = 1'b1;
`else
    localparam bit HazEn = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*10-1:0] req_x = '0;
    logic [NREQ*10-1:0] req_y = '0;
    logic [NREQ-1:0]   req_ready;
    logic [16:0]       rom_addr;
    logic [23:0]       rom_data = '0;
    logic              rsp_valid;
    logic [2:0]        rsp_id;
    logic [23:0]       rsp_color;
    logic              rsp_oob, rsp_lava, rsp_poison;

    map_probe_server #(.NREQ(NREQ), .MAP_W(640), .MAP_H(480)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_x_i      (req_x),
        .req_y_i      (req_y),
        .req_ready_o  (req_ready),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .rsp_valid_o  (rsp_valid),
        .rsp_id_o     (rsp_id),
        .rsp_color_o  (rsp_color),
        .rsp_oob_o    (rsp_oob),
        .rsp_lava_o   (rsp_lava),
        .rsp_poison_o (rsp_poison)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [23:0] rom_fn(logic [16:0] a);
        if (a == 17'd1625) return 24'hac0404;
        if (a == 17'd2) return 24'h69a42a;
        return {7'h0, a} ^ 24'h135790;
    endfunction

    always_ff @(posedge clk_i) rom_data <= rom_fn(rom_addr);

    typedef struct {
        int          due;
        int          id;
        logic [23:0] color;
        logic        oob;
    } exp_t;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] ready;
    } vec_t;

    exp_t q[$];
    int   ptr_m = 0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_xy(input int i, input int x, input int y);
        req_x[i*10 +: 10] = 10'(x);
        req_y[i*10 +: 10] = 10'(y);
    endtask

    // Called at a negedge with inputs already driven; returns the model's granted index.
    task automatic cycle(output int g);
        int   i, gx, gy, addr;
        logic oob;
        exp_t e;
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (ptr_m + k) % NREQ;
            if (g < 0 && req_valid[i]) g = i;
        end
        chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        gx = (g < 0) ? 0 : int'(req_x[g*10 +: 10]);
        gy = (g < 0) ? 0 : int'(req_y[g*10 +: 10]);
        @(posedge clk_i);
        #1;
        cyc++;
        if (g >= 0) begin
            ptr_m = (g + 1) % NREQ;
            oob   = (gx >= 640) || (gy >= 480);
            addr  = oob ? 0 : (gx / 4) + (gy / 4) * 160;
            chk("rom_addr", 32'(rom_addr), 32'(addr));
            e.due   = cyc + 2;
            e.id    = g;
            e.oob   = oob;
            e.color = oob ? 24'h0 : rom_fn(17'(addr));
            q.push_back(e);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_color", 32'(rsp_color), 32'(e.color));
            chk("rsp_oob", 32'(rsp_oob), 32'(e.oob));
            chk("rsp_lava", 32'(rsp_lava), 32'(HazEn && e.color == 24'hac0404));
            chk("rsp_poison", 32'(rsp_poison), 32'(HazEn && e.color == 24'h69a42a));
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk_i);
    endtask

    // Called at a negedge; holds reset for three cycles, releases on a negedge.
    task automatic do_reset();
        rst_ni = 1'b0;
        q.delete();
        ptr_m = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rom_addr", 32'(rom_addr), 32'd0);
            @(posedge clk_i);
            #1;
            chk("rst_rsp_valid_edge", 32'(rsp_valid), 32'd0);
            @(negedge clk_i);
        end
        chk("rst_rsp_fields", {rsp_color, rsp_id, rsp_oob, rsp_lava, rsp_poison}, 32'd0);
        rst_ni = 1'b1;
    endtask

    // r0 at (100,40) -> 1625 lava, r1 out of bounds, r2 -> addr 2 poison, r3 bottom row.
    vec_t tbl [12] = '{
        '{4'b0001, 4'b0001}, '{4'b0000, 4'b0000}, '{4'b0010, 4'b0010}, '{4'b0000, 4'b0000},
        '{4'b0101, 4'b0100}, '{4'b0101, 4'b0001}, '{4'b0101, 4'b0100}, '{4'b0101, 4'b0001},
        '{4'b1010, 4'b0010}, '{4'b1010, 4'b1000}, '{4'b0000, 4'b0000}, '{4'b0000, 4'b0000}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  g;
        bit  pend [NREQ];
        set_xy(0, 100, 40);
        set_xy(1, 640, 10);
        set_xy(2, 8, 0);
        set_xy(3, 300, 479);
        @(negedge clk_i);
        req_valid = '1;
        do_reset();

        for (int r = 0; r < 12; r++) begin
            req_valid = tbl[r].valid;
            #1;
            chk("tbl_ready", 32'(req_ready), 32'(tbl[r].ready));
            cycle(g);
        end

        // All four requesters at once after reset: 0,1,2,3 on consecutive edges.
        req_valid = '1;
        do_reset();
        for (int k = 0; k < NREQ; k++) begin
            #1;
            chk("rr_order", 32'(req_ready), 32'd1 << k);
            cycle(g);
            if (g >= 0) req_valid[g] = 1'b0;
        end
        for (int k = 0; k < 3; k++) cycle(g);

        // Reset one cycle after an accept drops the in-flight probe and rewinds the pointer.
        req_valid = 4'b0100;
        cycle(g);
        req_valid = '0;
        cycle(g);
        req_valid = 4'b0001;
        cycle(g);
        req_valid = '1;
        do_reset();
        #1;
        chk("post_reset_tie", 32'(req_ready), 32'd1);
        cycle(g);
        req_valid = '0;
        for (int k = 0; k < 3; k++) cycle(g);

        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(2) == 0) begin
                        pend[i] = 1'b1;
                        case ($urandom_range(7))
                            0: set_xy(i, 100, 40);
                            1: set_xy(i, 8, 0);
                            default: set_xy(i, $urandom_range(700), $urandom_range(520));
                        endcase
                    end
                end else if ($urandom_range(15) == 0) begin
                    pend[i] = 1'b0;
                end
                req_valid[i] = pend[i];
            end
            cycle(g);
            if (g >= 0) pend[g] = 1'b0;
        end
        req_valid = '0;
        for (int k = 0; k < 3; k++) cycle(g);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
